// File: rtl/pixel_scan_pkg.sv
// Shared types and default geometry for the raster scan generator.
// The tag struct travels down the delay line alongside each fetch request.
package pixel_scan_pkg;

  localparam int DEF_H_ACTIVE    = 1448;
  localparam int DEF_V_ACTIVE    = 1072;
  localparam int DEF_H_BLANK     = 32;
  localparam int DEF_V_BLANK_CYC = 64;
  localparam int DEF_PIPE_LAT    = 8;
  localparam int DEF_CW          = 12;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HBLANK,
    VBLANK
  } scan_state_e;

  typedef struct packed {
    logic valid;
    logic line_end;
    logic frame_end;
  } tag_t;

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth shift register that delays pixel tags by the colour pipeline latency.
// nonempty lets the scan generator stay busy until the last tag has drained.
module tag_delay_line #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             nonempty
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_q;
  logic [DEPTH-1:0][WIDTH-1:0] stage_d;

  always_comb begin
    stage_d[0] = din;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout     = stage_q[DEPTH-1];
  assign nonempty = |stage_q;

endmodule

// File: rtl/pixel_scan_gen.sv
// Raster scan generator: walks column/row with horizontal and vertical blanking,
// issues per-pixel fetch requests and delays pixel/line/frame tags to the sink.
module pixel_scan_gen
  import pixel_scan_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_BLANK     = DEF_H_BLANK,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_BLANK_CYC = DEF_V_BLANK_CYC,
  parameter int PIPE_LAT    = DEF_PIPE_LAT,
  parameter int CW          = DEF_CW
) (
  input  logic          pixel_clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          single_frame,
  output logic [CW-1:0] Pixel_Col_cnt,
  output logic [CW-1:0] Pixel_Row_cnt,
  output logic          pix_req,
  output logic          frame_start,
  output logic          out_valid,
  output logic          out_line_end,
  output logic          out_frame_end,
  output logic          busy
);

  localparam int BLANK_MAX = (H_BLANK > V_BLANK_CYC) ? H_BLANK : V_BLANK_CYC;
  localparam int BW        = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] HB_LAST  = BW'(H_BLANK - 1);
  localparam logic [BW-1:0] VB_LAST  = BW'(V_BLANK_CYC - 1);

  scan_state_e   state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic [BW-1:0] blank_q, blank_d;
  logic          pix_req_q, pix_req_d;
  logic          frame_start_q, frame_start_d;
  logic          single_q, single_d;
  tag_t          tag_in;
  tag_t          tag_out;
  logic          tags_in_flight;

  // Outputs are computed one cycle ahead so every scan output comes straight from a flop.
  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    row_d         = row_q;
    blank_d       = blank_q;
    pix_req_d     = 1'b0;
    frame_start_d = 1'b0;
    single_d      = single_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d       = ACTIVE;
          col_d         = '0;
          row_d         = '0;
          pix_req_d     = 1'b1;
          frame_start_d = 1'b1;
          single_d      = single_frame;
        end
      end
      ACTIVE: begin
        if (col_q == COL_LAST) begin
          state_d = HBLANK;
          blank_d = '0;
        end else begin
          col_d     = col_q + CW'(1);
          pix_req_d = 1'b1;
        end
      end
      HBLANK: begin
        if (blank_q == HB_LAST) begin
          blank_d = '0;
          if (row_q == ROW_LAST) begin
            state_d = VBLANK;
          end else begin
            state_d   = ACTIVE;
            row_d     = row_q + CW'(1);
            col_d     = '0;
            pix_req_d = 1'b1;
          end
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      VBLANK: begin
        // Enable is only honoured here and in IDLE, so a started frame always completes.
        if (blank_q == VB_LAST) begin
          blank_d = '0;
          if (enable && !single_q) begin
            state_d       = ACTIVE;
            col_d         = '0;
            row_d         = '0;
            pix_req_d     = 1'b1;
            frame_start_d = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      col_q         <= '0;
      row_q         <= '0;
      blank_q       <= '0;
      pix_req_q     <= 1'b0;
      frame_start_q <= 1'b0;
      single_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      blank_q       <= blank_d;
      pix_req_q     <= pix_req_d;
      frame_start_q <= frame_start_d;
      single_q      <= single_d;
    end
  end

  always_comb begin
    tag_in.valid     = pix_req_q;
    tag_in.line_end  = pix_req_q && (col_q == COL_LAST);
    tag_in.frame_end = pix_req_q && (col_q == COL_LAST) && (row_q == ROW_LAST);
  end

  tag_delay_line #(
    .DEPTH(PIPE_LAT),
    .WIDTH($bits(tag_t))
  ) u_tag_delay (
    .clk     (pixel_clk),
    .rst_n   (rst_n),
    .din     (tag_in),
    .dout    (tag_out),
    .nonempty(tags_in_flight)
  );

  assign Pixel_Col_cnt = col_q;
  assign Pixel_Row_cnt = row_q;
  assign pix_req       = pix_req_q;
  assign frame_start   = frame_start_q;
  assign out_valid     = tag_out.valid;
  assign out_line_end  = tag_out.line_end;
  assign out_frame_end = tag_out.frame_end;
  assign busy          = (state_q != IDLE) || tags_in_flight;

endmodule

// File: tb/tb_pixel_scan_gen.sv
// Self-checking bench for pixel_scan_gen using a frame-offset reference model
// on a small geometry, with directed scenarios followed by randomized enable/reset.
module tb_pixel_scan_gen;

  localparam int HA    = 4;
  localparam int HB    = 2;
  localparam int VA    = 3;
  localparam int VB    = 5;
  localparam int PL    = 3;
  localparam int CW    = 12;
  localparam int LP    = HA + HB;
  localparam int FRAME = VA * LP + VB;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          single_frame;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          pix_req;
  logic          frame_start;
  logic          out_valid;
  logic          out_line_end;
  logic          out_frame_end;
  logic          busy;

  pixel_scan_gen #(
    .H_ACTIVE   (HA),
    .H_BLANK    (HB),
    .V_ACTIVE   (VA),
    .V_BLANK_CYC(VB),
    .PIPE_LAT   (PL),
    .CW         (CW)
  ) dut (
    .pixel_clk    (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .single_frame (single_frame),
    .Pixel_Col_cnt(col),
    .Pixel_Row_cnt(row),
    .pix_req      (pix_req),
    .frame_start  (frame_start),
    .out_valid    (out_valid),
    .out_line_end (out_line_end),
    .out_frame_end(out_frame_end),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: position within the frame as a plain offset from frame_start.
  bit       m_run;
  int       m_k;
  bit       m_single;
  int       m_col;
  int       m_row;
  bit       m_pix;
  bit       m_fs;
  bit [2:0] dl [PL];

  int cnt_pix, cnt_fs, cnt_le, cnt_fe, cnt_valid;
  int fe_cyc, busy_fall_cyc;
  bit prev_busy;

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_run = 0; m_k = 0; m_single = 0;
    m_col = 0; m_row = 0; m_pix = 0; m_fs = 0;
    for (int i = 0; i < PL; i++) dl[i] = '0;
  endtask

  task automatic modelStep();
    bit [2:0] tin;
    int line, pos;
    tin[2] = m_pix;
    tin[1] = m_pix && (m_col == HA - 1);
    tin[0] = m_pix && (m_col == HA - 1) && (m_row == VA - 1);
    for (int i = PL - 1; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = tin;
    if (!m_run) begin
      if (enable) begin
        m_run = 1; m_k = 0; m_single = single_frame;
      end
    end else if (m_k == FRAME - 1) begin
      if (enable && !m_single) m_k = 0;
      else m_run = 0;
    end else begin
      m_k++;
    end
    m_pix = 0;
    m_fs  = 0;
    if (m_run) begin
      line = m_k / LP;
      pos  = m_k % LP;
      if (line < VA) begin
        m_row = line;
        m_col = (pos < HA) ? pos : HA - 1;
        m_pix = (pos < HA);
      end else begin
        m_row = VA - 1;
        m_col = HA - 1;
      end
      m_fs = (m_k == 0);
    end
  endtask

  function automatic bit modelBusy();
    bit b;
    b = m_run;
    for (int i = 0; i < PL; i++) if (dl[i] != 3'b000) b = 1;
    return b;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n) modelStep();
    end
  end

  task automatic checkOutput();
    checkVal("col",           int'(col),           m_col);
    checkVal("row",           int'(row),           m_row);
    checkVal("pix_req",       int'(pix_req),       int'(m_pix));
    checkVal("frame_start",   int'(frame_start),   int'(m_fs));
    checkVal("out_valid",     int'(out_valid),     int'(dl[PL-1][2]));
    checkVal("out_line_end",  int'(out_line_end),  int'(dl[PL-1][1]));
    checkVal("out_frame_end", int'(out_frame_end), int'(dl[PL-1][0]));
    checkVal("busy",          int'(busy),          int'(modelBusy()));
    if (pix_req) cnt_pix++;
    if (frame_start) cnt_fs++;
    if (out_line_end) cnt_le++;
    if (out_frame_end) begin cnt_fe++; fe_cyc = cyc; end
    if (out_valid) cnt_valid++;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_busy = busy;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      checkOutput();
    end
  end

  task automatic clearCounts();
    cnt_pix = 0; cnt_fs = 0; cnt_le = 0; cnt_fe = 0; cnt_valid = 0;
    fe_cyc = -1; busy_fall_cyc = -1;
  endtask

  task automatic applyStimulus(input bit en, input bit sf);
    @(negedge clk);
    enable       = en;
    single_frame = sf;
  endtask

  task automatic waitFs(input int max_cyc, output int at_cyc);
    bit ok;
    ok = 0;
    at_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (frame_start) begin ok = 1; at_cyc = cyc; break; end
    end
    checkVal("frame_start_seen", int'(ok), 1);
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic waitIdle(input int max_cyc);
    bit ok;
    ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    checkVal("idle_seen", int'(ok), 1);
  endtask

  task automatic assertReset();
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkVal("rst_col",       int'(col),       0);
    checkVal("rst_row",       int'(row),       0);
    checkVal("rst_pix_req",   int'(pix_req),   0);
    checkVal("rst_out_valid", int'(out_valid), 0);
    checkVal("rst_busy",      int'(busy),      0);
  endtask

  int fs0, fs1;

  initial begin
    rst_n = 1'b1;
    enable = 1'b0;
    single_frame = 1'b0;
    prev_busy = 0;
    modelReset();
    clearCounts();
    #1;
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    #1;
    checkVal("init_col", int'(col), 0);
    checkVal("init_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single frame");
    #1 clearCounts();
    applyStimulus(1'b1, 1'b1);
    waitFs(5, fs0);
    waitCyc(fs0 + 23);
    #1;
    checkVal("sf_pix_count",  cnt_pix, 12);
    checkVal("sf_fs_count",   cnt_fs, 1);
    checkVal("sf_line_ends",  cnt_le, 3);
    checkVal("sf_frame_ends", cnt_fe, 1);
    checkVal("sf_valid_count", cnt_valid, 12);
    checkVal("sf_fe_offset",  fe_cyc - fs0, 18);
    checkVal("sf_busy_fall",  busy_fall_cyc - fs0, 23);
    checkVal("sf_final_col",  int'(col), 3);
    checkVal("sf_final_row",  int'(row), 2);
    enable = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] continuous");
    applyStimulus(1'b1, 1'b0);
    waitFs(5, fs0);
    waitFs(30, fs1);
    checkVal("cont_frame_period", fs1 - fs0, 23);
    #1;
    checkVal("cont_wrap_row", int'(row), 0);
    applyStimulus(1'b0, 1'b0);
    waitIdle(60);

    $display("[TB] enable dropped mid-frame");
    @(negedge clk);
    #1 clearCounts();
    applyStimulus(1'b1, 1'b0);
    waitFs(5, fs0);
    waitCyc(fs0 + 7);
    enable = 1'b0;
    repeat (50) @(negedge clk);
    #1;
    checkVal("drop_pix_count", cnt_pix, 12);
    checkVal("drop_fs_count",  cnt_fs, 1);
    checkVal("drop_idle",      int'(busy), 0);

    $display("[TB] async reset mid-active");
    applyStimulus(1'b1, 1'b1);
    waitFs(5, fs0);
    waitCyc(fs0 + 8);
    #1;
    checkVal("pre_rst_col", int'(col), 2);
    checkVal("pre_rst_row", int'(row), 1);
    assertReset();
    clearCounts();
    @(negedge clk);
    rst_n = 1'b1;
    waitFs(5, fs0);
    #1;
    checkVal("restart_col", int'(col), 0);
    checkVal("restart_row", int'(row), 0);
    enable = 1'b0;
    waitCyc(fs0 + 2);
    #1;
    checkVal("no_stale_valid", cnt_valid, 0);
    waitIdle(60);

    $display("[TB] one-cycle enable");
    @(negedge clk);
    #1 clearCounts();
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    repeat (50) @(negedge clk);
    #1;
    checkVal("pulse_pix_count", cnt_pix, 12);
    checkVal("pulse_fs_count",  cnt_fs, 1);
    checkVal("pulse_le_count",  cnt_le, 3);

    $display("[TB] randomized");
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) enable = ~enable;
      single_frame = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 149) == 0) begin
        #($urandom_range(1, 3));
        rst_n = 1'b0;
        modelReset();
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    applyStimulus(1'b0, 1'b0);
    waitIdle(80);
    repeat (2) @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
